// File: rtl/pbutton_debounce.sv
// Push-button / switch input conditioning: synchroniser, per-bit debounce,
// edge pulses, sticky pending flags and a maskable interrupt.
module pbutton_debounce #(
  parameter int N_BTN       = 5,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1_000_000,
  localparam int CNT_W      = $clog2(DB_CYCLES)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_btn,
  output logic [N_BTN-1:0] o_rise,
  output logic [N_BTN-1:0] o_fall,
  input  logic [N_BTN-1:0] i_clr,
  input  logic [N_BTN-1:0] i_irq_en,
  output logic [N_BTN-1:0] o_pend,
  output logic             o_irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [N_BTN-1:0] sync_reg [SYNC_STAGES];
  logic [N_BTN-1:0] s;
  logic [N_BTN-1:0] accept;
  logic [N_BTN-1:0] btn_reg,  btn_next;
  logic [N_BTN-1:0] rise_reg, rise_next;
  logic [N_BTN-1:0] fall_reg, fall_next;
  logic [N_BTN-1:0] pend_reg, pend_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= '0;
      end
    end else begin
      sync_reg[0] <= i_btn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  // One run-length counter per bit; any sample matching the stable level
  // throws away the partial count.
  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_bit
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             differ;

      assign differ     = s[gi] ^ btn_reg[gi];
      assign accept[gi] = differ && (cnt_reg == CNT_MAX);

      always_comb begin
        cnt_next = '0;
        if (differ && (cnt_reg != CNT_MAX)) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

  // Pending: a rising edge beats a same-cycle clear so no press is lost.
  always_comb begin
    btn_next  = btn_reg ^ accept;
    rise_next = accept & s;
    fall_next = accept & ~s;
    pend_next = rise_reg | (pend_reg & ~i_clr);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btn_reg  <= '0;
      rise_reg <= '0;
      fall_reg <= '0;
      pend_reg <= '0;
    end else begin
      btn_reg  <= btn_next;
      rise_reg <= rise_next;
      fall_reg <= fall_next;
      pend_reg <= pend_next;
    end
  end

  assign o_btn  = btn_reg;
  assign o_rise = rise_reg;
  assign o_fall = fall_reg;
  assign o_pend = pend_reg;
  assign o_irq  = |(pend_reg & i_irq_en);

endmodule
